serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in, captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (state SHIFT).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid sum/cout.
REQ-010 SHALL have port sum  output  WIDTH  result bits, LSB first assembled.
REQ-011 SHALL have port cout  output  1  final carry-out.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE, all outputs registered.
REQ-013 IDLE: start=1 at an edge -> load a, b into shift registers, load carry flop with cin, clear bit counter, go SHIFT; start=0 -> stay IDLE.
REQ-014 SHIFT: each edge SHALL process one bit, LSB first: s = a0 ^ b0 ^ c; c_next = a0&b0 | a0&c | b0&c (full-adder equations).
REQ-015 SHIFT: each edge SHALL shift s into sum from the MSB end, shift the operand registers right by one, and increment the counter.
REQ-016 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1; SHIFT lasts exactly WIDTH cycles.
REQ-017 DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-018 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; busy high in the cycles after edges k..k+WIDTH-1.
REQ-019 On entry to DONE, sum SHALL equal (a + b + cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of the same sum.
REQ-020 sum and cout SHALL hold their values from DONE until the next accepted start; they are not cleared by returning to IDLE.
REQ-021 start while in SHIFT or DONE SHALL be ignored; no queuing; operands in flight SHALL NOT change.
REQ-022 Changes on a, b, cin outside the accepting edge SHALL NOT affect the result.
REQ-023 Back-to-back: start held high continuously SHALL produce one addition per WIDTH+2 cycles (accept, WIDTH shifts, done).
REQ-024 Carry ripple across all WIDTH bits (e.g. all-ones + 1) SHALL need no extra cycles.

Reset
REQ-025 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, operand registers=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-027 Reset SHALL take priority over start in the same cycle; the first start accepted is the first edge with rst_n=1 and start=1.

Verification
REQ-028 WIDTH=8, a=3, b=5, cin=0, start pulsed -> busy for 8 cycles, done pulse one cycle later, sum=8, cout=0.
REQ-029 a=255, b=1, cin=0 -> sum=0, cout=1; a=255, b=255, cin=1 -> sum=255, cout=1; a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-030 Start with a=10, b=20; pulse start with a=1, b=1 at cycle 3 of SHIFT -> single done, sum=30, cout=0, no second result.
REQ-031 Start a=100, b=100; drive rst_n=0 at cycle 4 of SHIFT -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse afterwards.
REQ-032 start held high with a=7, b=9, cin=1 -> done every 10 cycles, each with sum=17, cout=0.
REQ-033 Exhaustive at WIDTH=4: every a, b, cin combination checked against a+b+cin for sum and cout, with done timing per REQ-018.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in and produces
// their sum one bit per clock, LSB first, through a full adder and a carry flop.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s_bit, c_next;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        s_bit   = a_q[0] ^ b_q[0] ^ c_q;
        c_next  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastBit) begin
                    cout_d  = c_next;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 4-bit instance checked every cycle
// against a timeline model, plus directed, random and exhaustive stimulus.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy8, done8, cout8, busy4, done4, cout4;

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Model state per instance (0: WIDTH=8, 1: WIDTH=4).
    bit m_active[2];
    int m_acc[2];
    bit m_known[2];
    int m_sum[2];
    bit m_cout[2];
    int m_res[2];
    bit m_rc[2];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_update(input int id, input int w, input logic rn, input logic st,
                                input logic [31:0] av, input logic [31:0] bv, input logic ci);
        int     d;
        longint full;
        if (rn !== 1'b1) begin
            m_active[id] = 1'b0;
            m_known[id]  = 1'b1;
            m_sum[id]    = 0;
            m_cout[id]   = 1'b0;
        end else if (m_active[id]) begin
            d = edge_n - m_acc[id];
            if (d == w) begin
                m_sum[id]   = m_res[id];
                m_cout[id]  = m_rc[id];
                m_known[id] = 1'b1;
            end else if (d == w + 1) begin
                m_active[id] = 1'b0;
            end
        end else if (st === 1'b1) begin
            full         = longint'(av) + longint'(bv) + longint'(ci);
            m_res[id]    = int'(full % (longint'(1) << w));
            m_rc[id]     = ((full >> w) & 1) != 0;
            m_active[id] = 1'b1;
            m_acc[id]    = edge_n;
            m_known[id]  = 1'b0;
        end
    endtask

    task automatic model_check(input int id, input int w, input logic bo, input logic dn,
                               input logic [31:0] so, input logic co);
        int d;
        bit eb = 1'b0;
        bit ed = 1'b0;
        if (m_active[id]) begin
            d  = edge_n - m_acc[id];
            eb = d < w;
            ed = d == w;
        end
        chk((id == 0) ? "busy8" : "busy4", {31'b0, bo}, {31'b0, eb});
        chk((id == 0) ? "done8" : "done4", {31'b0, dn}, {31'b0, ed});
        if (m_known[id]) begin
            chk((id == 0) ? "sum8" : "sum4", so, m_sum[id]);
            chk((id == 0) ? "cout8" : "cout4", {31'b0, co}, {31'b0, m_cout[id]});
        end
    endtask

    // Single compare process: update the model at each edge, check #1 later.
    always begin
        @(posedge clk);
        edge_n++;
        model_update(0, 8, rst_n, start8, {24'b0, a8}, {24'b0, b8}, cin8);
        model_update(1, 4, rst_n, start4, {28'b0, a4}, {28'b0, b4}, cin4);
        #1;
        model_check(0, 8, busy8, done8, {24'b0, sum8}, cout8);
        model_check(1, 4, busy4, done4, {28'b0, sum4}, cout4);
    end

    // One 8-bit operation observed for 30 cycles, with optional start/reset injection.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int poke_at, input int rst_at,
                        output int busy_cnt, output int done_cnt, output int done_at,
                        output logic [7:0] s, output logic co);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        s        = '0;
        co       = 1'b0;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy8 === 1'b1) busy_cnt++;
            if (done8 === 1'b1) begin
                if (done_cnt == 0) begin
                    s = sum8; co = cout8; done_at = i;
                end
                done_cnt++;
            end
            if (i == rst_at + 1) begin
                s = sum8; co = cout8; rst_n = 1'b1;
            end
            if (i == 0) begin
                start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            if (i == poke_at) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0;
            end
            if (i == poke_at + 1) start8 = 1'b0;
            if (i == rst_at) rst_n = 1'b0;
        end
    endtask

    initial begin
        int         bc, dc, da, last, nd;
        logic [7:0] s;
        logic       co;
        logic [4:0] full4;
        bit         seen;

        // Reset held with start high: nothing may be accepted.
        start8 = 1'b1; a8 = 8'd55; b8 = 8'd66;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_sum", {24'b0, sum8}, 32'd0);
        chk("rst_cout", {31'b0, cout8}, 32'd0);
        start8 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        run8(8'd3, 8'd5, 1'b0, -5, -5, bc, dc, da, s, co);
        chk("basic_busy_cycles", bc, 32'd8);
        chk("basic_done_count", dc, 32'd1);
        chk("basic_done_latency", da, 32'd8);
        chk("basic_sum", {24'b0, s}, 32'd8);
        chk("basic_cout", {31'b0, co}, 32'd0);

        run8(8'd255, 8'd1, 1'b0, -5, -5, bc, dc, da, s, co);
        chk("ripple_sum", {24'b0, s}, 32'd0);
        chk("ripple_cout", {31'b0, co}, 32'd1);
        chk("ripple_latency", da, 32'd8);
        run8(8'd255, 8'd255, 1'b1, -5, -5, bc, dc, da, s, co);
        chk("max_sum", {24'b0, s}, 32'd255);
        chk("max_cout", {31'b0, co}, 32'd1);
        run8(8'd0, 8'd0, 1'b1, -5, -5, bc, dc, da, s, co);
        chk("cin_only_sum", {24'b0, s}, 32'd1);
        chk("cin_only_cout", {31'b0, co}, 32'd0);

        run8(8'd10, 8'd20, 1'b0, 2, -5, bc, dc, da, s, co);
        chk("ignore_start_dones", dc, 32'd1);
        chk("ignore_start_sum", {24'b0, s}, 32'd30);
        chk("ignore_start_cout", {31'b0, co}, 32'd0);

        run8(8'd100, 8'd100, 1'b0, -5, 3, bc, dc, da, s, co);
        chk("abort_busy_cycles", bc, 32'd4);
        chk("abort_dones", dc, 32'd0);
        chk("abort_sum", {24'b0, s}, 32'd0);
        chk("abort_cout", {31'b0, co}, 32'd0);

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; cin8 = 1'b1; start8 = 1'b1;
        last = -1;
        nd   = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                chk("held_sum", {24'b0, sum8}, 32'd17);
                chk("held_cout", {31'b0, cout8}, 32'd0);
                if (last >= 0) chk("held_period", i - last, 32'd10);
                last = i;
                nd++;
            end
        end
        start8 = 1'b0;
        chk("held_count", nd, 32'd4);
        repeat (12) @(negedge clk);

        // Random traffic on both instances with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n  = ($urandom % 80) != 0;
            start8 = ($urandom % 3) == 0;
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom);
            start4 = ($urandom % 3) == 0;
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            cin4   = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1; start8 = 1'b0; start4 = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    full4 = 5'(ia) + 5'(ib) + 5'(ic);
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    bc   = 0;
                    seen = 1'b0;
                    for (int i = 0; i < 12 && !seen; i++) begin
                        @(negedge clk);
                        if (i == 0) begin
                            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                        end
                        if (busy4 === 1'b1) bc++;
                        if (done4 === 1'b1) begin
                            seen = 1'b1;
                            chk("exh_sum", {28'b0, sum4}, {28'b0, full4[3:0]});
                            chk("exh_cout", {31'b0, cout4}, {31'b0, full4[4]});
                            chk("exh_latency", i, 32'd4);
                        end
                    end
                    chk("exh_done_seen", {31'b0, seen}, 32'd1);
                    chk("exh_busy_cycles", bc, 32'd4);
                    @(negedge clk);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
